rip_branch_target_buffer: RTL and testbench
===========================================

RIP_BRANCH_TARGET_BUFFER -- requirements
Module: rip_branch_target_buffer

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, entry-select width (2**INDEX_WIDTH entries).
REQ-002 SHALL have parameter TAG_WIDTH, default 8, stored tag width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc  input  32  fetch PC to look up.
REQ-006 SHALL have port lookup  input  1  capture pc this cycle; deasserted on stall.
REQ-007 SHALL have port pred  input  1  direction prediction for the captured pc, valid the cycle after capture.
REQ-008 SHALL have port hit  output  1  captured pc matched a valid entry.
REQ-009 SHALL have port target  output  32  stored target of matching entry, 0 on miss.
REQ-010 SHALL have port next_pc  output  32  selected next fetch address.
REQ-011 SHALL have port upd_valid  input  1  resolved control-transfer update strobe.
REQ-012 SHALL have port upd_pc  input  32  PC of resolved branch.
REQ-013 SHALL have port upd_target  input  32  resolved target.
REQ-014 SHALL have port upd_taken  input  1  resolved direction.
REQ-015 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-016 SHALL derive index = pc[2 +: INDEX_WIDTH], tag = pc[2+INDEX_WIDTH +: TAG_WIDTH]; same slicing for upd_pc.
REQ-017 SHALL, on an edge with lookup=1, register pc into pc_q and register hit/target from the indexed entry (1-cycle latency, aligned with pred).
REQ-018 SHALL, on an edge with lookup=0, hold pc_q, hit, target unchanged.
REQ-019 SHALL assert hit only when entry valid and stored tag equals pc tag; on miss target=0.
REQ-020 SHALL compute next_pc combinationally: hit&&pred ? target : pc_q+4, 32-bit wrap (0xFFFFFFFC+4 = 0x00000000).
REQ-021 SHALL, on upd_valid=1 with upd_taken=1, write entry[upd index] = {valid=1, upd tag, upd_target}, replacing any occupant.
REQ-022 SHALL, on upd_valid=1 with upd_taken=0, leave the table unchanged.
REQ-023 SHALL, on flush=1, clear all valid bits in that single edge; flush wins over a same-cycle update (update dropped).
REQ-024 SHALL, on a same-cycle lookup and flush, register hit=0.
REQ-025 SHALL store targets in full 32 bits; no alignment truncation.

Reset
REQ-026 SHALL, on edge with rstn=0, clear all valid bits, pc_q=0, hit=0, target=0; next_pc therefore 0x00000004.
REQ-027 SHALL ignore lookup, upd_valid, flush while rstn=0; reset mid-operation discards all learned entries.
REQ-028 SHALL NOT reset tag/target storage (only valid bits).

Configuration
REQ-029 SHALL honour macro RIP_BTB_BYPASS_EN.
REQ-030 SHALL, with RIP_BTB_BYPASS_EN defined, return the update's data when a lookup and a taken update hit the same index in the same cycle (write-first: hit=1 if tags match, target=upd_target).
REQ-031 SHALL, without RIP_BTB_BYPASS_EN, return the pre-update entry contents in that case (read-first).

Verification
REQ-032 Reset, then lookup pc=0x100 -> hit=0, target=0, next_pc=0x104 next cycle.
REQ-033 Update upd_pc=0x100, upd_target=0x200, upd_taken=1; later lookup 0x100 with pred=1 -> hit=1, next_pc=0x200; with pred=0 -> next_pc=0x104.
REQ-034 After REQ-033, lookup 0x100+(4<<INDEX_WIDTH)*... aliasing pc 0x500 (same index, different tag) -> hit=0; taken update at 0x500 target 0x600 then lookup 0x100 -> hit=0.
REQ-035 Lookup 0x100 then hold lookup=0 three cycles while pc changes -> hit/target/next_pc stable; then flush=1 with simultaneous taken update -> subsequent lookups of both PCs miss.
REQ-036 Same-cycle lookup and taken update at 0x300 target 0x800 -> hit=1,target=0x800 with RIP_BTB_BYPASS_EN; hit=0 without; next-cycle re-lookup hits in both builds.
REQ-037 Lookup pc=0xFFFFFFFC on miss -> next_pc=0x00000000; rstn=0 pulse after training -> previously trained PC misses.

Source files
------------

// File: rtl/rip_branch_target_buffer.sv
// Direct-mapped branch target buffer with a registered one-cycle lookup and next-fetch-address selection.
// Build option: define RIP_BTB_BYPASS_EN for write-first forwarding of a same-cycle taken update.
module rip_branch_target_buffer #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  input  logic        lookup,
  input  logic        pred,
  output logic        hit,
  output logic [31:0] target,
  output logic [31:0] next_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = 2 + INDEX_WIDTH;
  localparam int TAG_TOP = TAG_LSB + TAG_WIDTH;

  logic [ENTRIES-1:0]   valid;
  logic [TAG_WIDTH-1:0] tag_mem    [ENTRIES];
  logic [31:0]          target_mem [ENTRIES];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   wr_en;
  logic                   rd_hit;
  logic [31:0]            rd_target;

  logic [31:0] pc_q;
  logic        hit_q;
  logic [31:0] target_q;

  assign lk_idx = pc[2 +: INDEX_WIDTH];
  assign lk_tag = pc[TAG_LSB +: TAG_WIDTH];
  assign up_idx = upd_pc[2 +: INDEX_WIDTH];
  assign up_tag = upd_pc[TAG_LSB +: TAG_WIDTH];

  // A flush in the same cycle drops the update entirely.
  assign wr_en = upd_valid && upd_taken && !flush;

  // Alignment bits and PC bits above the tag take no part in the match.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], pc[31:TAG_TOP], upd_pc[1:0], upd_pc[31:TAG_TOP]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    rd_target = rd_hit ? target_mem[lk_idx] : 32'd0;
`ifdef RIP_BTB_BYPASS_EN
    if (wr_en && (up_idx == lk_idx)) begin
      rd_hit    = (up_tag == lk_tag);
      rd_target = rd_hit ? upd_target : 32'd0;
    end
`endif
    if (flush) begin
      rd_hit    = 1'b0;
      rd_target = 32'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid    <= '0;
      pc_q     <= 32'd0;
      hit_q    <= 1'b0;
      target_q <= 32'd0;
    end else begin
      if (lookup) begin
        pc_q     <= pc;
        hit_q    <= rd_hit;
        target_q <= rd_target;
      end
      if (flush) begin
        valid <= '0;
      end else if (wr_en) begin
        valid[up_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag/target storage has no reset; the valid bits alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= upd_target;
    end
  end

  assign hit     = hit_q;
  assign target  = target_q;
  assign next_pc = (hit_q && pred) ? target_q : pc_q + 32'd4;

endmodule

// File: tb/tb_rip_branch_target_buffer.sv
// Self-checking bench for rip_branch_target_buffer: directed vector table plus randomized traffic
// compared against an associative-array reference model.
module tb_rip_branch_target_buffer;

  localparam int IW      = 6;
  localparam int TW      = 8;
  localparam int ENTRIES = 1 << IW;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        lookup;
  logic        pred;
  logic        hit;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush;

  rip_branch_target_buffer #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .lookup(lookup), .pred(pred),
    .hit(hit), .target(target), .next_pc(next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        lookup;
    logic [31:0] pc;
    logic        pred;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        flush;
    logic        exp_hit;
    logic [31:0] exp_target;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a live entry exists in the arrays only while valid.
  int unsigned m_tag [int];
  logic [31:0] m_tgt [int];
  logic [31:0] m_pcq;
  logic        m_hit;
  logic [31:0] m_target;

  function automatic vec_t mk(logic r, logic lk, logic [31:0] p, logic pr, logic uv, logic ut,
                              logic [31:0] up, logic [31:0] utg, logic fl,
                              logic eh, logic [31:0] et, logic [31:0] en);
    vec_t v;
    v.rstn = r; v.lookup = lk; v.pc = p; v.pred = pr;
    v.upd_valid = uv; v.upd_taken = ut; v.upd_pc = up; v.upd_target = utg; v.flush = fl;
    v.exp_hit = eh; v.exp_target = et; v.exp_next = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rstn = v.rstn; lookup = v.lookup; pc = v.pc; pred = v.pred;
    upd_valid = v.upd_valid; upd_taken = v.upd_taken; upd_pc = v.upd_pc;
    upd_target = v.upd_target; flush = v.flush;
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return int'((a >> (2 + IW)) % (1 << TW));
  endfunction

  task automatic model_step(input vec_t v);
    int  li, ui;
    bit  wr;
    if (!v.rstn) begin
      m_tag.delete(); m_tgt.delete();
      m_pcq = 0; m_hit = 0; m_target = 0;
      return;
    end
    li = idx_of(v.pc);
    ui = idx_of(v.upd_pc);
    wr = v.upd_valid && v.upd_taken && !v.flush;
    if (v.lookup) begin
      m_pcq = v.pc;
      if (v.flush) begin
        m_hit = 0; m_target = 0;
      end else begin
        m_hit    = m_tag.exists(li) && (m_tag[li] == tag_of(v.pc));
        m_target = m_hit ? m_tgt[li] : 32'd0;
`ifdef RIP_BTB_BYPASS_EN
        if (wr && ui == li) begin
          m_hit    = (tag_of(v.upd_pc) == tag_of(v.pc));
          m_target = m_hit ? v.upd_target : 32'd0;
        end
`endif
      end
    end
    if (v.flush) begin
      m_tag.delete(); m_tgt.delete();
    end else if (wr) begin
      m_tag[ui] = tag_of(v.upd_pc);
      m_tgt[ui] = v.upd_target;
    end
  endtask

  initial begin
    vec_t v;
    rstn = 0; lookup = 0; pc = 0; pred = 0;
    upd_valid = 0; upd_taken = 0; upd_pc = 0; upd_target = 0; flush = 0;

    //            rstn lk pc            pred uv ut upd_pc        upd_target    fl  hit target        next_pc
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h4));
    vecs.push_back(mk(1, 1, 32'h100,      0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h104));
    vecs.push_back(mk(1, 0, 32'h100,      0, 1, 1, 32'h100,     32'h200,      0, 0, 32'h0,        32'h104));
    vecs.push_back(mk(1, 1, 32'h100,      1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h200,      32'h200));
    vecs.push_back(mk(1, 1, 32'h100,      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h200,      32'h104));
    vecs.push_back(mk(1, 1, 32'h500,      1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h504));
    vecs.push_back(mk(1, 0, 32'h500,      1, 1, 1, 32'h500,     32'h600,      0, 0, 32'h0,        32'h504));
    vecs.push_back(mk(1, 1, 32'h100,      1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h104));
    vecs.push_back(mk(1, 1, 32'h500,      1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h600,      32'h600));
    vecs.push_back(mk(1, 0, 32'h100,      1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h600,      32'h600));
    vecs.push_back(mk(1, 0, 32'h300,      1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h600,      32'h600));
    vecs.push_back(mk(1, 0, 32'h40,       1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h600,      32'h600));
    vecs.push_back(mk(1, 0, 32'h40,       1, 1, 1, 32'h100,     32'h200,      1, 1, 32'h600,      32'h600));
    vecs.push_back(mk(1, 1, 32'h500,      1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h504));
    vecs.push_back(mk(1, 1, 32'h100,      1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h104));
    vecs.push_back(mk(1, 1, 32'h300,      1, 1, 0, 32'h300,     32'h900,      0, 0, 32'h0,        32'h304));
    vecs.push_back(mk(1, 1, 32'h300,      1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h304));
`ifdef RIP_BTB_BYPASS_EN
    vecs.push_back(mk(1, 1, 32'h300,      1, 1, 1, 32'h300,     32'h800,      0, 1, 32'h800,      32'h800));
`else
    vecs.push_back(mk(1, 1, 32'h300,      1, 1, 1, 32'h300,     32'h800,      0, 0, 32'h0,        32'h304));
`endif
    vecs.push_back(mk(1, 1, 32'h300,      1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h800,      32'h800));
    vecs.push_back(mk(1, 1, 32'h300,      1, 0, 0, 32'h0,       32'h0,        1, 0, 32'h0,        32'h304));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h1234,    32'hABCDEF01, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 32'h1234,     1, 0, 0, 32'h0,       32'h0,        0, 1, 32'hABCDEF01, 32'hABCDEF01));
    vecs.push_back(mk(0, 1, 32'h1234,     1, 1, 1, 32'h1234,    32'h77,       1, 0, 32'h0,        32'h4));
    vecs.push_back(mk(1, 1, 32'h1234,     1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        32'h1238));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d hit", i),     {31'd0, hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d target", i),  target,       vecs[i].exp_target);
      check($sformatf("vec%0d next_pc", i), next_pc,      vecs[i].exp_next);
    end

    // Hand sequence: training survives several idle cycles, then a single-cycle
    // reset pulse discards it.
    apply(mk(1, 0, 32'h0, 0, 1, 1, 32'h2A8, 32'h3C, 0, 0, 32'h0, 32'h0));
    for (int i = 0; i < 3; i++) apply(mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    apply(mk(1, 1, 32'h2A8, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    check("seq trained next_pc", next_pc, 32'h3C);
    apply(mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    apply(mk(1, 1, 32'h2A8, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    check("seq after reset hit", {31'd0, hit}, 32'd0);
    check("seq after reset next_pc", next_pc, 32'h2AC);

    // Randomized traffic over a small address pool so indices alias and tags collide.
    v = mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    apply(v);
    model_step(v);
    for (int i = 0; i < 600; i++) begin
      v.rstn       = ($urandom_range(0, 99) != 0);
      v.lookup     = ($urandom_range(0, 3) != 0);
      v.pc         = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 19) == 0) v.pc = $urandom;
      v.pred       = 1'($urandom_range(0, 1));
      v.upd_valid  = 1'($urandom_range(0, 1));
      v.upd_taken  = ($urandom_range(0, 9) < 7);
      v.upd_pc     = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      v.upd_target = $urandom;
      v.flush      = ($urandom_range(0, 29) == 0);
      apply(v);
      model_step(v);
      check($sformatf("rnd%0d hit", i),     {31'd0, hit}, {31'd0, m_hit});
      check($sformatf("rnd%0d target", i),  target,       m_target);
      check($sformatf("rnd%0d next_pc", i), next_pc,
            (m_hit && v.pred) ? m_target : m_pcq + 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
